// File: rtl/cmac_rx_pkg.sv
// Shared types for the CMAC RX packet FIFO: buffer entry layout and writer FSM states.
package cmac_rx_pkg;

  localparam int unsigned CMAC_DATA_WIDTH = 512;
  localparam int unsigned CMAC_STRB_WIDTH = CMAC_DATA_WIDTH / 8;

  // Buffer word layout, MSB first; the RAM stores entries packed in this order.
  typedef struct packed {
    logic                       last;
    logic [CMAC_STRB_WIDTH-1:0] strb;
    logic [CMAC_DATA_WIDTH-1:0] data;
  } rx_entry_t;

  typedef enum logic [0:0] {
    StPass,
    StDrop
  } wr_state_e;

endpackage

// File: rtl/cmac_rx_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module cmac_rx_sdp_ram
  import cmac_rx_pkg::*;
#(
  parameter int unsigned C_DEPTH_LOG2 = 9,
  parameter int unsigned C_WIDTH      = 577
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [C_DEPTH_LOG2-1:0] wr_addr,
  input  logic [C_WIDTH-1:0]      wr_data,
  input  logic                    rd_en,
  input  logic [C_DEPTH_LOG2-1:0] rd_addr,
  output logic [C_WIDTH-1:0]      rd_data
);

  logic [C_WIDTH-1:0] mem [0:(1 << C_DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cmac_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: accepts every input beat, releases only whole packets.
module cmac_rx_pkt_fifo
  import cmac_rx_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 512,
  parameter int unsigned C_DEPTH_LOG2 = 9,
  parameter int unsigned C_CNT_WIDTH  = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      S_AXIS_TVALID,
  input  logic                      S_AXIS_TLAST,
  input  logic [C_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [C_DATA_WIDTH-1:0]   S_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TLAST,
  output logic [C_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic [C_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_CNT_WIDTH-1:0]    PKT_COUNT,
  output logic [C_CNT_WIDTH-1:0]    DROP_COUNT
);

  localparam int unsigned EntryW = 1 + C_DATA_WIDTH / 8 + C_DATA_WIDTH;
  localparam int unsigned PtrW   = C_DEPTH_LOG2 + 1;
  localparam logic [PtrW-1:0] FullUsed = {1'b1, {C_DEPTH_LOG2{1'b0}}};

  wr_state_e             state_q, state_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, wr_tmp_q, wr_tmp_d, rd_ptr_q;
  logic [PtrW-1:0]       wr_tmp_inc, used;
  logic                  full, wr_en, pkt_inc, drop_inc;
  logic                  rd_en, pend_q, pop;
  logic [1:0]            occ;
  logic [EntryW-1:0]     rd_data;
  logic [EntryW-1:0]     head_q, head_d, spare_q, spare_d;
  logic                  head_vld_q, head_vld_d, spare_vld_q, spare_vld_d;
  logic [C_CNT_WIDTH-1:0] pkt_cnt_q, drop_cnt_q;

  assign wr_tmp_inc = wr_tmp_q + 1'b1;
  assign used       = wr_tmp_q - rd_ptr_q;
  assign full       = (used == FullUsed);

  // Writer: speculative writes at wr_tmp, published to the reader only on TLAST.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_tmp_d = wr_tmp_q;
    wr_en    = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    if (S_AXIS_TVALID) begin
      unique case (state_q)
        StPass: begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_tmp_d = wr_tmp_inc;
            if (S_AXIS_TLAST) begin
              wr_ptr_d = wr_tmp_inc;
              pkt_inc  = 1'b1;
            end
          end else begin
            wr_tmp_d = wr_ptr_q;
            if (S_AXIS_TLAST) drop_inc = 1'b1;
            else              state_d  = StDrop;
          end
        end
        StDrop: begin
          if (S_AXIS_TLAST) begin
            drop_inc = 1'b1;
            state_d  = StPass;
          end
        end
        default: state_d = StPass;
      endcase
    end
  end

  // Reader: an issued read lands one cycle later, so it needs a prefetch slot reserved.
  assign pop   = head_vld_q & M_AXIS_TREADY;
  assign occ   = 2'(head_vld_q) + 2'(spare_vld_q) + 2'(pend_q);
  assign rd_en = (rd_ptr_q != wr_ptr_q) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  always_comb begin
    head_d      = head_q;
    head_vld_d  = head_vld_q;
    spare_d     = spare_q;
    spare_vld_d = spare_vld_q;
    if (!head_vld_q || pop) begin
      if (spare_vld_q) begin
        head_d      = spare_q;
        head_vld_d  = 1'b1;
        spare_vld_d = pend_q;
        if (pend_q) spare_d = rd_data;
      end else begin
        head_vld_d = pend_q;
        if (pend_q) head_d = rd_data;
      end
    end else if (pend_q) begin
      spare_d     = rd_data;
      spare_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StPass;
      wr_ptr_q    <= '0;
      wr_tmp_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= 1'b0;
      head_q      <= '0;
      head_vld_q  <= 1'b0;
      spare_vld_q <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_tmp_q    <= wr_tmp_d;
      pend_q      <= rd_en;
      head_q      <= head_d;
      head_vld_q  <= head_vld_d;
      spare_vld_q <= spare_vld_d;
      if (rd_en)    rd_ptr_q   <= rd_ptr_q + 1'b1;
      if (pkt_inc)  pkt_cnt_q  <= pkt_cnt_q + 1'b1;
      if (drop_inc) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    spare_q <= spare_d;
  end

  cmac_rx_sdp_ram #(
    .C_DEPTH_LOG2(C_DEPTH_LOG2),
    .C_WIDTH     (EntryW)
  ) u_ram (
    .clk    (CLK),
    .wr_en  (wr_en),
    .wr_addr(wr_tmp_q[C_DEPTH_LOG2-1:0]),
    .wr_data({S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TDATA}),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr_q[C_DEPTH_LOG2-1:0]),
    .rd_data(rd_data)
  );

  assign M_AXIS_TVALID = head_vld_q;
  assign {M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TDATA} = head_q;
  assign PKT_COUNT  = pkt_cnt_q;
  assign DROP_COUNT = drop_cnt_q;

endmodule

// File: tb/tb_cmac_rx_pkt_fifo.sv
// Directed bench for cmac_rx_pkt_fifo with a 16-beat buffer and an output scoreboard.
module tb_cmac_rx_pkt_fifo;

  localparam int unsigned DW    = 512;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned DEPTH = 16;

  logic          CLK, RST;
  logic          S_AXIS_TVALID, S_AXIS_TLAST;
  logic [SW-1:0] S_AXIS_TSTRB;
  logic [DW-1:0] S_AXIS_TDATA;
  logic          M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [SW-1:0] M_AXIS_TSTRB;
  logic [DW-1:0] M_AXIS_TDATA;
  logic [31:0]   PKT_COUNT, DROP_COUNT;

  cmac_rx_pkt_fifo #(
    .C_DATA_WIDTH(DW),
    .C_DEPTH_LOG2(4),
    .C_CNT_WIDTH (32)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST (S_AXIS_TLAST),
    .S_AXIS_TSTRB (S_AXIS_TSTRB),
    .S_AXIS_TDATA (S_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TSTRB (M_AXIS_TSTRB),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .PKT_COUNT    (PKT_COUNT),
    .DROP_COUNT   (DROP_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_run  = 0;
  int n_fail = 0;
  int fires  = 0;
  int bursts = 0;
  bit rand_ready = 1'b0;
  logic [SW+DW:0] exp_q[$];

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard compare on every handshake, hold check on every stall.
  logic [SW+DW:0] prev_beat;
  bit prev_stall = 1'b0, prev_fire = 1'b0, prev_rst = 1'b1;
  always @(negedge CLK) begin
    logic [SW+DW:0] beat;
    bit fire;
    beat = {M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TDATA};
    fire = (M_AXIS_TVALID === 1'b1) && (M_AXIS_TREADY === 1'b1);
    if (!prev_rst && prev_stall) begin
      chk("hold_valid", 640'(M_AXIS_TVALID), 640'(1'b1));
      chk("hold_beat", 640'(beat), 640'(prev_beat));
    end
    if (fire) begin
      if (exp_q.size() == 0) begin
        n_run++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed %0h expected no beat", beat);
        end
      end else begin
        chk("out_beat", 640'(beat), 640'(exp_q.pop_front()));
      end
      fires++;
      if (!prev_fire) bursts++;
    end
    prev_fire  = fire;
    prev_stall = (M_AXIS_TVALID === 1'b1) && (M_AXIS_TREADY !== 1'b1);
    prev_beat  = beat;
    prev_rst   = (RST !== 1'b0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_ready) M_AXIS_TREADY = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [DW-1:0] mk_data(input int p, input int b);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
    d[31:0] = {p[15:0], b[15:0]};
    return d;
  endfunction

  task automatic send_beat(input logic last, input logic [SW-1:0] strb, input logic [DW-1:0] data,
                           input bit push);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TLAST  = last;
    S_AXIS_TSTRB  = strb;
    S_AXIS_TDATA  = data;
    if (push) exp_q.push_back({last, strb, data});
    tick();
  endtask

  task automatic send_pkt(input int p, input int len, input bit push);
    for (int b = 0; b < len; b++)
      send_beat(b == len - 1, {$urandom, $urandom}, mk_data(p, b), push);
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 640'(exp_q.size()), 640'(0));
    repeat (3) tick();
  endtask

  initial begin
    int f0, b0, len, n;
    RST = 1'b1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TSTRB  = '0;
    S_AXIS_TDATA  = '0;
    M_AXIS_TREADY = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", 640'(M_AXIS_TVALID), 640'(0));
    chk("rst_tlast", 640'(M_AXIS_TLAST), 640'(0));
    chk("rst_tstrb", 640'(M_AXIS_TSTRB), 640'(0));
    chk("rst_tdata", 640'(M_AXIS_TDATA), 640'(0));
    chk("rst_pkt_count", 640'(PKT_COUNT), 640'(0));
    chk("rst_drop_count", 640'(DROP_COUNT), 640'(0));
    RST = 1'b0;
    M_AXIS_TREADY = 1'b1;
    tick();

    // Single-beat packet: commit at edge t, output valid after edge t+2.
    send_beat(1'b1, 64'h0000_0000_0000_FFFF, mk_data(7, 0), 1'b1);
    S_AXIS_TVALID = 1'b0;
    chk("one_pkt_count", 640'(PKT_COUNT), 640'(1));
    chk("one_valid_t", 640'(M_AXIS_TVALID), 640'(0));
    tick();
    chk("one_valid_t1", 640'(M_AXIS_TVALID), 640'(0));
    tick();
    chk("one_valid_t2", 640'(M_AXIS_TVALID), 640'(1));
    chk("one_tstrb", 640'(M_AXIS_TSTRB), 640'(64'h0000_0000_0000_FFFF));
    chk("one_tlast", 640'(M_AXIS_TLAST), 640'(1));
    drain("one_drain");

    // 100 back-to-back 4-beat packets stream out as a single gap-free burst.
    f0 = fires;
    b0 = bursts;
    for (int p = 0; p < 100; p++) send_pkt(100 + p, 4, 1'b1);
    drain("b2b_drain");
    chk("b2b_beats", 640'(fires - f0), 640'(400));
    chk("b2b_bursts", 640'(bursts - b0), 640'(1));
    chk("b2b_pkt_count", 640'(PKT_COUNT), 640'(101));
    chk("b2b_drop_count", 640'(DROP_COUNT), 640'(0));

    // Stalled output: two 7-beat packets stored; two of their beats move into the prefetch
    // buffer, leaving 4 free entries, so the third overflows at its fifth beat.
    M_AXIS_TREADY = 1'b0;
    f0 = fires;
    send_pkt(300, 7, 1'b1);
    send_pkt(301, 7, 1'b1);
    send_pkt(302, 7, 1'b0);
    repeat (4) tick();
    chk("ovf_drop_count", 640'(DROP_COUNT), 640'(1));
    chk("ovf_pkt_count", 640'(PKT_COUNT), 640'(103));
    chk("ovf_stalled_valid", 640'(M_AXIS_TVALID), 640'(1));
    chk("ovf_no_beats", 640'(fires - f0), 640'(0));
    M_AXIS_TREADY = 1'b1;
    drain("ovf_drain");
    chk("ovf_beats", 640'(fires - f0), 640'(14));

    // Packet longer than the buffer is dropped whole; the next one passes.
    f0 = fires;
    send_pkt(400, 20, 1'b0);
    repeat (6) tick();
    chk("long_drop_count", 640'(DROP_COUNT), 640'(2));
    chk("long_no_beats", 640'(fires - f0), 640'(0));
    send_pkt(401, 2, 1'b1);
    drain("long_next_drain");
    chk("long_next_beats", 640'(fires - f0), 640'(2));
    chk("long_pkt_count", 640'(PKT_COUNT), 640'(104));

    // Random lengths with 50% TREADY; each packet waits until it is sure to fit.
    rand_ready = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      len = int'($urandom_range(1, 8));
      n = 0;
      while (exp_q.size() + len > DEPTH && n < 1000) begin
        tick();
        n++;
      end
      chk("rand_space_wait", 640'(n < 1000), 640'(1));
      send_pkt(1000 + p, len, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 1'b0;
    M_AXIS_TREADY = 1'b1;
    drain("rand_drain");
    chk("rand_pkt_count", 640'(PKT_COUNT), 640'(1104));
    chk("rand_drop_count", 640'(DROP_COUNT), 640'(2));

    // Reset mid-packet with three packets buffered: everything is flushed.
    M_AXIS_TREADY = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(5000 + p, 2, 1'b0);
    send_beat(1'b0, '1, mk_data(5003, 0), 1'b0);
    S_AXIS_TVALID = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_tvalid", 640'(M_AXIS_TVALID), 640'(0));
    chk("mid_rst_tlast", 640'(M_AXIS_TLAST), 640'(0));
    chk("mid_rst_tstrb", 640'(M_AXIS_TSTRB), 640'(0));
    chk("mid_rst_tdata", 640'(M_AXIS_TDATA), 640'(0));
    chk("mid_rst_pkt_count", 640'(PKT_COUNT), 640'(0));
    chk("mid_rst_drop_count", 640'(DROP_COUNT), 640'(0));
    M_AXIS_TREADY = 1'b1;
    f0 = fires;
    repeat (20) tick();
    chk("mid_rst_no_beats", 640'(fires - f0), 640'(0));
    chk("mid_rst_tvalid_after", 640'(M_AXIS_TVALID), 640'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
